pipe_hazard_ctrl: RTL



---
 rtl/pipe_ctrl_pkg.sv | 28 ++
 rtl/pipe_hazard_ctrl_hazard_detect.sv | 49 ++++
 rtl/pipe_hazard_ctrl.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_pkg
// Description : Shared types for the pipeline sequencing controller.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2,
        ST_ERROR  = 2'd3
    } state_t;

    // Destination index width is a module parameter, so it lives beside the struct.
    localparam int c_SLOT_FLAGS_W = 5;

    typedef struct packed {
        logic valid;
        logic wr;
        logic ld;
        logic halt;
        logic err;
    } slot_flags_t;

endpackage
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
`default_nettype none
// ============================================================================
// Module      : hazard_detect
// Description : Combinational RAW / load-use hazard comparator for ID.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_detect #(
    parameter int FORWARDING = 1,
    parameter int REG_W      = 3
) (
    input  logic             i_id_valid,
    input  logic [REG_W-1:0] i_id_rs,
    input  logic [REG_W-1:0] i_id_rt,
    input  logic             i_id_uses_rs,
    input  logic             i_id_uses_rt,
    input  logic             i_ex_valid,
    input  logic             i_ex_wr,
    input  logic             i_ex_ld,
    input  logic [REG_W-1:0] i_ex_dest,
    input  logic             i_mem_valid,
    input  logic             i_mem_wr,
    input  logic [REG_W-1:0] i_mem_dest,
    output logic             o_hz
);

    logic w_ex_match;
    logic w_mem_match;

    assign w_ex_match  = (i_id_uses_rs & (i_id_rs == i_ex_dest)) |
                         (i_id_uses_rt & (i_id_rt == i_ex_dest));
    assign w_mem_match = (i_id_uses_rs & (i_id_rs == i_mem_dest)) |
                         (i_id_uses_rt & (i_id_rt == i_mem_dest));

    generate
        if (FORWARDING != 0) begin : g_fwd
            // Bypass paths cover everything except data still in flight from a load.
            logic w_unused;
            assign w_unused = &{1'b0, i_mem_valid, i_mem_wr, w_mem_match};
            assign o_hz = i_id_valid & i_ex_valid & i_ex_ld & i_ex_wr & w_ex_match;
        end else begin : g_nofwd
            logic w_unused;
            assign w_unused = &{1'b0, i_ex_ld};
            assign o_hz = i_id_valid & ((i_ex_valid  & i_ex_wr  & w_ex_match) |
                                        (i_mem_valid & i_mem_wr & w_mem_match));
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl
// Description : Shadow pipe, hazard stalls, redirect squash and halt drain FSM.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int FORWARDING = 1,
    parameter int REG_W      = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_reg_write,
    input  logic [REG_W-1:0] id_dest,
    input  logic             id_mem_read,
    input  logic             id_halt,
    input  logic             id_err,
    input  logic             ex_redirect,
    input  logic             mem_busy,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_en,
    output logic             id_ex_bubble,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             halt_out,
    output logic             err_out
);

    state_t           r_state;
    slot_flags_t      r_ex, r_mem, r_wb;
    logic [REG_W-1:0] r_ex_dest, r_mem_dest, r_wb_dest;
    logic             r_halt, r_err;

    logic w_hz, w_advance, w_shift;
    logic w_pc_en, w_if_id_en, w_if_id_flush, w_id_ex_en, w_id_ex_bubble;
    logic w_ex_mem_en, w_mem_wb_en;
    logic w_unused;

    hazard_detect #(
        .FORWARDING (FORWARDING),
        .REG_W      (REG_W)
    ) u_hazard_detect (
        .i_id_valid   (id_valid),
        .i_id_rs      (id_rs),
        .i_id_rt      (id_rt),
        .i_id_uses_rs (id_uses_rs),
        .i_id_uses_rt (id_uses_rt),
        .i_ex_valid   (r_ex.valid),
        .i_ex_wr      (r_ex.wr),
        .i_ex_ld      (r_ex.ld),
        .i_ex_dest    (r_ex_dest),
        .i_mem_valid  (r_mem.valid),
        .i_mem_wr     (r_mem.wr),
        .i_mem_dest   (r_mem_dest),
        .o_hz         (w_hz)
    );

    // WB only matters for retirement; its register fields are carried for observability.
    assign w_unused = &{1'b0, r_wb_dest, r_wb.wr, r_wb.ld};

    always_comb begin
        w_pc_en        = 1'b0;
        w_if_id_en     = 1'b0;
        w_if_id_flush  = 1'b0;
        w_id_ex_en     = 1'b0;
        w_id_ex_bubble = 1'b0;
        w_ex_mem_en    = 1'b0;
        w_mem_wb_en    = 1'b0;
        if (rst_n && !mem_busy) begin
            case (r_state)
                ST_RUN: begin
                    w_id_ex_en  = 1'b1;
                    w_ex_mem_en = 1'b1;
                    w_mem_wb_en = 1'b1;
                    if (ex_redirect) begin
                        w_pc_en        = 1'b1;
                        w_if_id_en     = 1'b1;
                        w_if_id_flush  = 1'b1;
                        w_id_ex_bubble = 1'b1;
                    end else if (w_hz) begin
                        w_id_ex_bubble = 1'b1;
                    end else begin
                        w_pc_en    = 1'b1;
                        w_if_id_en = 1'b1;
                    end
                end
                ST_DRAIN: begin
                    w_if_id_en     = 1'b1;
                    w_if_id_flush  = 1'b1;
                    w_id_ex_en     = 1'b1;
                    w_id_ex_bubble = 1'b1;
                    w_ex_mem_en    = 1'b1;
                    w_mem_wb_en    = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign w_advance = (r_state == ST_RUN) & ~mem_busy & ~ex_redirect & ~w_hz;
    assign w_shift   = ~mem_busy & ((r_state == ST_RUN) | (r_state == ST_DRAIN));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_RUN;
            r_ex       <= '0;
            r_mem      <= '0;
            r_wb       <= '0;
            r_ex_dest  <= '0;
            r_mem_dest <= '0;
            r_wb_dest  <= '0;
            r_halt     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            if (w_shift) begin
                if (w_id_ex_bubble) begin
                    r_ex      <= '0;
                    r_ex_dest <= '0;
                end else begin
                    r_ex      <= '{valid: id_valid, wr: id_reg_write, ld: id_mem_read,
                                   halt: id_halt, err: id_err};
                    r_ex_dest <= id_dest;
                end
                r_mem      <= r_ex;
                r_mem_dest <= r_ex_dest;
                r_wb       <= r_mem;
                r_wb_dest  <= r_mem_dest;
            end
            case (r_state)
                ST_RUN: begin
                    if (w_advance && id_valid && (id_halt || id_err))
                        r_state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (!mem_busy && r_wb.valid) begin
                        if (r_wb.err) begin
                            r_state <= ST_ERROR;
                            r_err   <= 1'b1;
                            r_halt  <= 1'b1;
                        end else if (r_wb.halt) begin
                            r_state <= ST_HALTED;
                            r_halt  <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign pc_en        = w_pc_en;
    assign if_id_en     = w_if_id_en;
    assign if_id_flush  = w_if_id_flush;
    assign id_ex_en     = w_id_ex_en;
    assign id_ex_bubble = w_id_ex_bubble;
    assign ex_mem_en    = w_ex_mem_en;
    assign mem_wb_en    = w_mem_wb_en;
    assign halt_out     = r_halt;
    assign err_out      = r_err;

endmodule
`default_nettype wire
